// File: rtl/score_board.sv
// score_board: keeps both players' scores from the rolling 2-bit miss counters,
// runs the RUN/OVER match state machine, and scans the four-digit active-low
// seven-segment display. After the match ends, the display blinks.
module score_board #(
    parameter int REFRESH_DIV = 50000,  // mclk cycles per digit slot
    parameter int WIN_SCORE   = 11,     // score that ends the match (1..99)
    parameter int BLINK_SCANS = 64      // full scans per blink half-period
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic [1:0] lose1,
    input  logic [1:0] lose2,
    input  logic       game_clr,
    output logic [3:0] seg_select,
    output logic [6:0] seg_LED,
    output logic       match_over,
    output logic [1:0] winner
);

    // One blink half-period measured in clock cycles. A full scan is 4 digit slots.
    localparam int BLINK_PERIOD = BLINK_SCANS * 4 * REFRESH_DIV;
    localparam int SLOT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLINK_W      = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

    localparam logic [6:0]         WIN        = 7'(WIN_SCORE);
    localparam logic [7:0]         WIN_EXT    = 8'(WIN_SCORE);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD - 1);

    localparam logic [6:0] SEG_DARK = 7'b1111111;
    localparam logic [3:0] SEL_DARK = 4'b1111;

    typedef enum logic {
        RUN  = 1'b0,
        OVER = 1'b1
    } state_t;

    // Match state and scores
    state_t      state_reg, state_next;
    logic [6:0]  score1_reg, score1_next;
    logic [6:0]  score2_reg, score2_next;
    logic [1:0]  winner_reg, winner_next;
    logic [1:0]  prev1_reg, prev2_reg;

    // Miss decode
    logic [1:0]  d1, d2;
    logic [7:0]  sum1, sum2;
    logic        reach1, reach2;
    logic [6:0]  sat1, sat2;

    // Display scan and blink
    logic [SLOT_W-1:0]  slot_reg;
    logic [1:0]         digit_reg;
    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               dark_reg;

    // Digit content
    logic [3:0]  tens1, ones1, tens2, ones2;
    logic [3:0]  digit_val;
    logic        digit_blank;
    logic [3:0]  sel_next;
    logic [6:0]  led_next;
    logic [3:0]  sel_reg;
    logic [6:0]  led_reg;

    // Active-low gfedcba pattern for one decimal digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DARK;
        endcase
        return s;
    endfunction

    // Misses since last cycle; 2-bit subtraction gives the mod-4 distance,
    // so a wrap 11->00 reads as a single miss.
    assign d1 = lose1 - prev1_reg;
    assign d2 = lose2 - prev2_reg;

    // A miss by one player scores for the other. Saturate at the winning score.
    assign sum1   = {1'b0, score1_reg} + {6'b0, d2};
    assign sum2   = {1'b0, score2_reg} + {6'b0, d1};
    assign reach1 = (sum1 >= WIN_EXT);
    assign reach2 = (sum2 >= WIN_EXT);
    assign sat1   = reach1 ? WIN : sum1[6:0];
    assign sat2   = reach2 ? WIN : sum2[6:0];

    // Match FSM next state and score updates; game_clr overrides any delta.
    always_comb begin
        state_next  = state_reg;
        score1_next = score1_reg;
        score2_next = score2_reg;
        winner_next = winner_reg;
        if (game_clr) begin
            state_next  = RUN;
            score1_next = 7'd0;
            score2_next = 7'd0;
            winner_next = 2'b00;
        end else begin
            case (state_reg)
                RUN: begin
                    score1_next = sat1;
                    score2_next = sat2;
                    if (reach1 || reach2) begin
                        state_next  = OVER;
                        winner_next = {reach2, reach1};
                    end
                end
                default: begin
                    // Scores frozen until the match is cleared.
                end
            endcase
        end
    end

    // Match state register; prev tracks the counters every cycle, even when frozen.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            state_reg  <= RUN;
            score1_reg <= 7'd0;
            score2_reg <= 7'd0;
            winner_reg <= 2'b00;
            prev1_reg  <= 2'b00;
            prev2_reg  <= 2'b00;
        end else begin
            state_reg  <= state_next;
            score1_reg <= score1_next;
            score2_reg <= score2_next;
            winner_reg <= winner_next;
            prev1_reg  <= lose1;
            prev2_reg  <= lose2;
        end
    end

    // Digit slot timer; the digit index advances each time a slot expires.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            slot_reg  <= '0;
            digit_reg <= 2'd0;
        end else if (slot_reg == SLOT_LAST) begin
            slot_reg  <= '0;
            digit_reg <= digit_reg + 2'd1;
        end else begin
            slot_reg  <= slot_reg + SLOT_W'(1);
        end
    end

    // Blink timer: runs only in OVER, restarts lit on every entry to OVER or clear.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            blink_cnt_reg <= '0;
            dark_reg      <= 1'b0;
        end else if (state_reg != OVER || game_clr) begin
            blink_cnt_reg <= '0;
            dark_reg      <= 1'b0;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            dark_reg      <= ~dark_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
        end
    end

    // Binary to two decimal digits (scores never exceed 99).
    assign tens1 = 4'(score1_reg / 7'd10);
    assign ones1 = 4'(score1_reg % 7'd10);
    assign tens2 = 4'(score2_reg / 7'd10);
    assign ones2 = 4'(score2_reg % 7'd10);

    // Pick the digit for the current slot and build the next select/segment pair.
    always_comb begin
        digit_val   = 4'd0;
        digit_blank = 1'b0;
        case (digit_reg)
            2'd0: digit_val = ones2;
            2'd1: begin
                digit_val   = tens2;
                digit_blank = (score2_reg < 7'd10);
            end
            2'd2: digit_val = ones1;
            default: begin
                digit_val   = tens1;
                digit_blank = (score1_reg < 7'd10);
            end
        endcase
        if (state_reg == OVER && dark_reg) begin
            sel_next = SEL_DARK;
            led_next = SEG_DARK;
        end else begin
            sel_next = ~(4'b0001 << digit_reg);
            led_next = digit_blank ? SEG_DARK : seg_encode(digit_val);
        end
    end

    // Display output registers: select and segments always update together.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            sel_reg <= SEL_DARK;
            led_reg <= SEG_DARK;
        end else begin
            sel_reg <= sel_next;
            led_reg <= led_next;
        end
    end

    assign seg_select = sel_reg;
    assign seg_LED    = led_reg;
    assign match_over = (state_reg == OVER);
    assign winner     = winner_reg;

endmodule

// File: tb/tb_score_board.sv
// tb_score_board: directed and randomized miss streams against a cycle-level
// model that tracks scores, match end and display timing from plain arithmetic.
module tb_score_board;

    localparam int R = 4;            // REFRESH_DIV
    localparam int B = 2;            // BLINK_SCANS
    localparam int W = 11;           // WIN_SCORE
    localparam int P = B * 4 * R;    // blink half-period in cycles

    logic       mclk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] lose1 = 2'b00;
    logic [1:0] lose2 = 2'b00;
    logic       game_clr = 1'b0;
    logic [3:0] seg_select;
    logic [6:0] seg_LED;
    logic       match_over;
    logic [1:0] winner;

    score_board #(
        .REFRESH_DIV(R),
        .WIN_SCORE  (W),
        .BLINK_SCANS(B)
    ) dut (
        .mclk      (mclk),
        .rst       (rst),
        .lose1     (lose1),
        .lose2     (lose2),
        .game_clr  (game_clr),
        .seg_select(seg_select),
        .seg_LED   (seg_LED),
        .match_over(match_over),
        .winner    (winner)
    );

    always #5 mclk = ~mclk;

    int tests = 0;
    int fails = 0;

    // Reference model state (values after the most recent clock edge)
    int n;        // edges since reset release
    int s1, s2;   // scores
    int p1, p2;   // last seen counter values
    int over;     // match ended
    int win;      // winner code
    int entry;    // edge at which the match ended

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    function automatic int digit_pattern(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Advance one clock edge, update the model from the sampled inputs and
    // compare all outputs one time unit later.
    task automatic step();
        int ps1, ps2, pover, pentry, idx, v, exp_sel, exp_led, m1, m2;
        ps1 = s1; ps2 = s2; pover = over; pentry = entry;
        @(posedge mclk);
        n++;
        if (game_clr) begin
            s1 = 0; s2 = 0; over = 0; win = 0;
        end else if (over == 0) begin
            m1 = (int'(lose1) - p1 + 4) % 4;
            m2 = (int'(lose2) - p2 + 4) % 4;
            s1 = min_int(s1 + m2, W);
            s2 = min_int(s2 + m1, W);
            if (s1 >= W || s2 >= W) begin
                over  = 1;
                win   = ((s2 >= W) ? 2 : 0) + ((s1 >= W) ? 1 : 0);
                entry = n;
            end
        end
        p1 = int'(lose1);
        p2 = int'(lose2);
        #1;
        // Display registered on this edge reflects the state before it.
        if (pover != 0 && (((n - 1 - pentry) / P) % 2) == 1) begin
            exp_sel = 4'b1111;
            exp_led = 7'b1111111;
        end else begin
            idx     = ((n - 1) / R) % 4;
            exp_sel = (~(1 << idx)) & 4'hF;
            case (idx)
                0: v = ps2 % 10;
                1: v = (ps2 < 10) ? -1 : ps2 / 10;
                2: v = ps1 % 10;
                default: v = (ps1 < 10) ? -1 : ps1 / 10;
            endcase
            exp_led = digit_pattern(v);
        end
        check("seg_select", int'(seg_select), exp_sel);
        check("seg_LED", int'(seg_LED), exp_led);
        check("match_over", int'(match_over), over);
        check("winner", int'(winner), win);
    endtask

    // Assert reset away from a clock edge, verify the display goes dark at once,
    // then release it away from an edge and reset the model.
    task automatic do_reset();
        @(posedge mclk);
        #3;
        rst = 1'b0;
        game_clr = 1'b0;
        #1;
        check("rst_seg_select", int'(seg_select), 4'b1111);
        check("rst_seg_LED", int'(seg_LED), 7'b1111111);
        check("rst_match_over", int'(match_over), 0);
        check("rst_winner", int'(winner), 0);
        lose1 = 2'b00;
        lose2 = 2'b00;
        @(posedge mclk);
        #1;
        rst = 1'b1;
        n = 0; s1 = 0; s2 = 0; p1 = 0; p2 = 0; over = 0; win = 0; entry = 0;
    endtask

    task automatic run_steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        n = 0; s1 = 0; s2 = 0; p1 = 0; p2 = 0; over = 0; win = 0; entry = 0;

        // Reset, then idle scan of zeros
        do_reset();
        step();
        check("first_digit_sel", int'(seg_select), 4'b1110);
        check("first_digit_led", int'(seg_LED), 7'b1000000);
        run_steps(4);
        check("second_digit_sel", int'(seg_select), 4'b1101);
        run_steps(12);

        // Single P2 miss scores for P1
        lose2 = 2'b01;
        step();
        run_steps(16);

        // P1 misses three at once, then wraps 11->00
        lose1 = 2'b11;
        step();
        lose1 = 2'b00;
        step();
        run_steps(16);

        // Both miss on the same cycle
        lose1 = lose1 + 2'd1;
        lose2 = lose2 + 2'd1;
        step();
        run_steps(16);

        // Drive P1 to 10, then a +3 saturates at 11 and ends the match
        do_reset();
        for (int i = 0; i < 3; i++) begin
            lose2 = lose2 + 2'd3;
            step();
        end
        lose2 = lose2 + 2'd1;
        step();
        lose2 = lose2 + 2'd3;
        step();
        check("win_match_over", int'(match_over), 1);
        check("win_winner", int'(winner), 1);
        // Frozen scores and blinking while more misses arrive
        for (int i = 0; i < 90; i++) begin
            if ($urandom_range(0, 3) == 0) lose1 = lose1 + 2'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) lose2 = lose2 + 2'($urandom_range(1, 3));
            step();
        end

        // Clear during OVER with a same-cycle miss: nothing counted
        game_clr = 1'b1;
        lose1 = lose1 + 2'd1;
        step();
        game_clr = 1'b0;
        check("clr_winner", int'(winner), 0);
        check("clr_match_over", int'(match_over), 0);
        run_steps(16);

        // Randomized matches with occasional clears
        for (int m = 0; m < 15; m++) begin
            for (int i = 0; i < 300 && over == 0; i++) begin
                if ($urandom_range(0, 3) == 0) lose1 = lose1 + 2'($urandom_range(1, 3));
                if ($urandom_range(0, 3) == 0) lose2 = lose2 + 2'($urandom_range(1, 3));
                game_clr = ($urandom_range(0, 49) == 0);
                step();
                game_clr = 1'b0;
            end
            for (int i = 0; i < 70; i++) begin
                if ($urandom_range(0, 2) == 0) lose1 = lose1 + 2'($urandom_range(1, 3));
                if ($urandom_range(0, 2) == 0) lose2 = lose2 + 2'($urandom_range(1, 3));
                step();
            end
            game_clr = 1'b1;
            if ($urandom_range(0, 1) == 1) lose2 = lose2 + 2'($urandom_range(1, 3));
            step();
            game_clr = 1'b0;
        end

        // Score a little, then reset in the middle of the digit-2 slot
        lose2 = lose2 + 2'd2;
        lose1 = lose1 + 2'd1;
        step();
        for (int i = 0; i < 16 && (((n - 1) / R) % 4) != 2; i++) step();
        check("digit2_slot_sel", int'(seg_select), 4'b1011);
        do_reset();
        run_steps(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
